// File: rtl/icache_fill_unit_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache fill unit.
// The cache itself uses the master view; the fetch stage / memory controller side uses slave.
interface icache_fill_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] proc2icache_addr;
  logic            proc2icache_valid;
  logic [63:0]     icache2proc_data;
  logic            icache2proc_valid;
  logic [1:0]      icache_command;
  logic [XLEN-1:0] icache_addr;
  logic            icache_is_miss;
  logic [3:0]      control2cache_response;
  logic            control2cache_response_which;
  logic [63:0]     control2cache_data;
  logic [3:0]      control2cache_tag;
  logic            control2cache_tag_which;

  modport master (
    input  proc2icache_addr,
    input  proc2icache_valid,
    output icache2proc_data,
    output icache2proc_valid,
    output icache_command,
    output icache_addr,
    output icache_is_miss,
    input  control2cache_response,
    input  control2cache_response_which,
    input  control2cache_data,
    input  control2cache_tag,
    input  control2cache_tag_which
  );

  modport slave (
    output proc2icache_addr,
    output proc2icache_valid,
    input  icache2proc_data,
    input  icache2proc_valid,
    input  icache_command,
    input  icache_addr,
    input  icache_is_miss,
    output control2cache_response,
    output control2cache_response_which,
    output control2cache_data,
    output control2cache_tag,
    output control2cache_tag_which
  );
endinterface

// File: rtl/icache_fill_unit.sv
// Direct-mapped blocking instruction cache with a single-outstanding-miss fill engine.
// Hits return combinationally; a miss issues one BUS_LOAD, remembers the memory tag
// granted for it and writes the line when the ICACHE-owned data with that tag returns.
module icache_fill_unit #(
  parameter int NUM_LINES = 32,
  parameter int XLEN      = 32
) (
  input logic                clock,
  input logic                reset,
  icache_fill_unit_if.master bus
);
  localparam int IDX    = $clog2(NUM_LINES);
  localparam int LINE_W = XLEN - 3;
  localparam int TAG_W  = XLEN - IDX - 3;

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam logic       ICACHE   = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t                state_q;
  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [63:0]           data_q [NUM_LINES];
  logic [LINE_W-1:0]     line_addr_q;
  logic [3:0]            mem_tag_q;
  logic [1:0]            cmd_q;
  logic [XLEN-1:0]       req_addr_q;

  logic [IDX-1:0]        cur_idx;
  logic [TAG_W-1:0]      cur_tag;
  logic [LINE_W-1:0]     cur_line;
  logic [IDX-1:0]        line_idx;
  logic [TAG_W-1:0]      line_tag;
  logic                  hit;
  logic                  miss;
  logic                  grant;
  logic                  data_match;
  logic                  fill_we;
  logic [2:0]            unused_offset;

  assign cur_idx       = bus.proc2icache_addr[IDX+2:3];
  assign cur_tag       = bus.proc2icache_addr[XLEN-1:IDX+3];
  assign cur_line      = bus.proc2icache_addr[XLEN-1:3];
  assign unused_offset = bus.proc2icache_addr[2:0];
  assign line_idx      = line_addr_q[IDX-1:0];
  assign line_tag      = line_addr_q[LINE_W-1:IDX];

  assign hit  = bus.proc2icache_valid & valid_q[cur_idx] & (tag_q[cur_idx] == cur_tag);
  assign miss = bus.proc2icache_valid & ~hit;

  // A grant or data beat only counts when it belongs to the instruction cache
  assign grant      = (bus.control2cache_response != 4'd0) &
                      (bus.control2cache_response_which == ICACHE);
  assign data_match = (bus.control2cache_tag != 4'd0) &
                      (bus.control2cache_tag_which == ICACHE) &
                      (bus.control2cache_tag == mem_tag_q);
  assign fill_we    = (state_q == S_WAIT) & data_match & ~reset;

  assign bus.icache2proc_valid = hit;
  assign bus.icache2proc_data  = hit ? data_q[cur_idx] : 64'd0;
  assign bus.icache_is_miss    = miss;
  assign bus.icache_command    = cmd_q;
  assign bus.icache_addr       = req_addr_q;

  // Fill FSM: tracks the single outstanding miss and drives the registered request outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      line_addr_q <= '0;
      mem_tag_q   <= '0;
      cmd_q       <= BUS_NONE;
      req_addr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (miss) begin
            state_q     <= S_REQ;
            line_addr_q <= cur_line;
            cmd_q       <= BUS_LOAD;
            req_addr_q  <= {cur_line, 3'b000};
          end
        end
        S_REQ: begin
          if (grant) begin
            state_q    <= S_WAIT;
            mem_tag_q  <= bus.control2cache_response;
            cmd_q      <= BUS_NONE;
            req_addr_q <= '0;
          end else if (hit) begin
            // Fetch moved to a resident line before anything was granted
            state_q    <= S_IDLE;
            cmd_q      <= BUS_NONE;
            req_addr_q <= '0;
          end else if (miss && (cur_line != line_addr_q)) begin
            // Nothing outstanding yet, so chase the new fetch line
            line_addr_q <= cur_line;
            req_addr_q  <= {cur_line, 3'b000};
          end
        end
        S_WAIT: begin
          if (data_match) begin
            state_q           <= S_IDLE;
            valid_q[line_idx] <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Line tag/data storage, written only when the awaited fill data arrives
  always_ff @(posedge clock) begin
    if (fill_we) begin
      tag_q[line_idx]  <= line_tag;
      data_q[line_idx] <= bus.control2cache_data;
    end
  end
endmodule

// File: tb/tb_icache_fill_unit.sv
// Directed bench for icache_fill_unit: a table of per-cycle input/expected-output rows
// plus hand-written sequences for reset behaviour.
module tb_icache_fill_unit;
  localparam int XLEN      = 32;
  localparam int NUM_LINES = 32;

  localparam logic       I = 1'b1;   // ICACHE owner
  localparam logic       D = 1'b0;   // DCACHE owner
  localparam logic [1:0] L = 2'd1;   // BUS_LOAD
  localparam logic [1:0] N = 2'd0;   // BUS_NONE

  typedef struct packed {
    logic [31:0] addr;
    logic        vld;
    logic [3:0]  resp;
    logic        rw;
    logic [63:0] data;
    logic [3:0]  tag;
    logic        tw;
    logic        ehit;
    logic [63:0] edata;
    logic [1:0]  ecmd;
    logic [31:0] eaddr;
    logic        emiss;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];

  icache_fill_unit_if #(.XLEN(XLEN)) bus ();

  icache_fill_unit #(.NUM_LINES(NUM_LINES), .XLEN(XLEN)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic add(input logic [31:0] addr, input logic vld, input logic [3:0] resp,
                     input logic rw, input logic [63:0] data, input logic [3:0] tag,
                     input logic tw, input logic ehit, input logic [63:0] edata,
                     input logic [1:0] ecmd, input logic [31:0] eaddr, input logic emiss);
    vec_t v;
    v.addr = addr; v.vld = vld; v.resp = resp; v.rw = rw; v.data = data;
    v.tag = tag; v.tw = tw; v.ehit = ehit; v.edata = edata; v.ecmd = ecmd;
    v.eaddr = eaddr; v.emiss = emiss;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [31:0] addr, input logic vld, input logic [3:0] resp,
                       input logic rw, input logic [63:0] data, input logic [3:0] tag,
                       input logic tw);
    bus.proc2icache_addr             = addr;
    bus.proc2icache_valid            = vld;
    bus.control2cache_response       = resp;
    bus.control2cache_response_which = rw;
    bus.control2cache_data           = data;
    bus.control2cache_tag            = tag;
    bus.control2cache_tag_which      = tw;
  endtask

  task automatic check(input string name, input logic ehit, input logic [63:0] edata,
                       input logic [1:0] ecmd, input logic [31:0] eaddr, input logic emiss);
    n_tests += 5;
    if (bus.icache2proc_valid !== ehit) begin
      n_fail++;
      $display("FAIL %s icache2proc_valid got %b want %b", name, bus.icache2proc_valid, ehit);
    end
    if (bus.icache2proc_data !== edata) begin
      n_fail++;
      $display("FAIL %s icache2proc_data got %h want %h", name, bus.icache2proc_data, edata);
    end
    if (bus.icache_command !== ecmd) begin
      n_fail++;
      $display("FAIL %s icache_command got %0d want %0d", name, bus.icache_command, ecmd);
    end
    if (bus.icache_addr !== eaddr) begin
      n_fail++;
      $display("FAIL %s icache_addr got %h want %h", name, bus.icache_addr, eaddr);
    end
    if (bus.icache_is_miss !== emiss) begin
      n_fail++;
      $display("FAIL %s icache_is_miss got %b want %b", name, bus.icache_is_miss, emiss);
    end
  endtask

  initial begin
    // Cold miss on 0x1000: one-cycle BUS_LOAD, grant tag 3, data two cycles later
    add(32'h1000, 1, 0, I, 64'h0, 0, I,                      0, 64'h0, N, 32'h0,    1);
    add(32'h1000, 1, 3, I, 64'h0, 0, I,                      0, 64'h0, L, 32'h1000, 1);
    add(32'h1000, 1, 0, I, 64'h0, 0, I,                      0, 64'h0, N, 32'h0,    1);
    add(32'h1000, 1, 0, I, 64'hDEADBEEF_CAFEF00D, 3, I,      0, 64'h0, N, 32'h0,    1);
    add(32'h1000, 1, 0, I, 64'h0, 0, I,                      1, 64'hDEADBEEF_CAFEF00D, N, 32'h0, 0);
    add(32'h1004, 1, 0, I, 64'h0, 0, I,                      1, 64'hDEADBEEF_CAFEF00D, N, 32'h0, 0);
    add(32'h1004, 0, 0, I, 64'h0, 0, I,                      0, 64'h0, N, 32'h0,    0);
    // Wrong-owner grant and data on 0x48
    add(32'h48, 1, 0, I, 64'h0, 0, I,                        0, 64'h0, N, 32'h0,  1);
    add(32'h48, 1, 5, D, 64'h0, 0, I,                        0, 64'h0, L, 32'h48, 1);
    add(32'h48, 1, 0, I, 64'h0, 0, I,                        0, 64'h0, L, 32'h48, 1);
    add(32'h48, 1, 5, I, 64'h0, 0, I,                        0, 64'h0, L, 32'h48, 1);
    add(32'h48, 1, 0, I, 64'h1111_2222_3333_4444, 5, D,      0, 64'h0, N, 32'h0,  1);
    add(32'h48, 1, 0, I, 64'h0, 0, I,                        0, 64'h0, N, 32'h0,  1);
    add(32'h48, 1, 0, I, 64'h5555_6666_7777_8888, 5, I,      0, 64'h0, N, 32'h0,  1);
    add(32'h48, 1, 0, I, 64'h0, 0, I,                        1, 64'h5555_6666_7777_8888, N, 32'h0, 0);
    add(32'h4C, 1, 0, I, 64'h0, 0, I,                        1, 64'h5555_6666_7777_8888, N, 32'h0, 0);
    // Tag mismatch on 0x50: mem_tag 2, data tag 7 ignored
    add(32'h50, 1, 0, I, 64'h0, 0, I,                        0, 64'h0, N, 32'h0,  1);
    add(32'h50, 1, 2, I, 64'h0, 0, I,                        0, 64'h0, L, 32'h50, 1);
    add(32'h50, 1, 0, I, 64'hAAAA_AAAA_AAAA_AAAA, 7, I,      0, 64'h0, N, 32'h0,  1);
    add(32'h50, 1, 0, I, 64'h0, 0, I,                        0, 64'h0, N, 32'h0,  1);
    add(32'h50, 1, 0, I, 64'h0123_4567_89AB_CDEF, 2, I,      0, 64'h0, N, 32'h0,  1);
    add(32'h50, 1, 0, I, 64'h0, 0, I,                        1, 64'h0123_4567_89AB_CDEF, N, 32'h0, 0);
    // Retarget 0x2000 -> 0x3000 before grant
    add(32'h2000, 1, 0, I, 64'h0, 0, I,                      0, 64'h0, N, 32'h0,    1);
    add(32'h3000, 1, 0, I, 64'h0, 0, I,                      0, 64'h0, L, 32'h2000, 1);
    add(32'h3000, 1, 6, I, 64'h0, 0, I,                      0, 64'h0, L, 32'h3000, 1);
    add(32'h3000, 1, 0, I, 64'h3333_0000_3333_0000, 6, I,    0, 64'h0, N, 32'h0,    1);
    add(32'h3000, 1, 0, I, 64'h0, 0, I,                      1, 64'h3333_0000_3333_0000, N, 32'h0, 0);
    // 0x1000 was evicted; moving back to resident 0x3000 in REQ abandons the request
    add(32'h1000, 1, 0, I, 64'h0, 0, I,                      0, 64'h0, N, 32'h0,    1);
    add(32'h3000, 1, 0, I, 64'h0, 0, I,                      1, 64'h3333_0000_3333_0000, L, 32'h1000, 0);
    add(32'h3000, 0, 0, I, 64'h0, 0, I,                      0, 64'h0, N, 32'h0,    0);
    // Conflict eviction: 0x0000 then 0x0100 share index 0
    add(32'h0, 1, 0, I, 64'h0, 0, I,                         0, 64'h0, N, 32'h0,   1);
    add(32'h0, 1, 1, I, 64'h0, 0, I,                         0, 64'h0, L, 32'h0,   1);
    add(32'h0, 1, 0, I, 64'h0000_0000_0000_0A0A, 1, I,       0, 64'h0, N, 32'h0,   1);
    add(32'h0, 1, 0, I, 64'h0, 0, I,                         1, 64'h0000_0000_0000_0A0A, N, 32'h0, 0);
    add(32'h100, 1, 0, I, 64'h0, 0, I,                       0, 64'h0, N, 32'h0,   1);
    add(32'h100, 1, 2, I, 64'h0, 0, I,                       0, 64'h0, L, 32'h100, 1);
    add(32'h100, 1, 0, I, 64'h0000_0000_0000_0B0B, 2, I,     0, 64'h0, N, 32'h0,   1);
    add(32'h100, 1, 0, I, 64'h0, 0, I,                       1, 64'h0000_0000_0000_0B0B, N, 32'h0, 0);
    add(32'h0, 1, 0, I, 64'h0, 0, I,                         0, 64'h0, N, 32'h0,   1);
    add(32'h100, 1, 0, I, 64'h0, 0, I,                       1, 64'h0000_0000_0000_0B0B, L, 32'h0, 0);
    add(32'h100, 0, 0, I, 64'h0, 0, I,                       0, 64'h0, N, 32'h0,   0);
    add(32'h48, 1, 0, I, 64'h0, 0, I,                        1, 64'h5555_6666_7777_8888, N, 32'h0, 0);

    // Reset state, checked while reset is still held so no transition occurs
    reset = 1'b1;
    drive(32'h1000, 1, 0, I, 64'h0, 0, I);
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1 check("reset_miss", 0, 64'h0, N, 32'h0, 1);
    @(negedge clock);
    drive(32'h1000, 0, 0, I, 64'h0, 0, I);
    #1 check("reset_idle", 0, 64'h0, N, 32'h0, 0);

    // Table rows: one cycle each, inputs at the falling edge, outputs sampled 1 time unit later
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clock);
      reset = 1'b0;
      drive(vecs[k].addr, vecs[k].vld, vecs[k].resp, vecs[k].rw,
            vecs[k].data, vecs[k].tag, vecs[k].tw);
      #1 check($sformatf("vec%0d", k), vecs[k].ehit, vecs[k].edata,
               vecs[k].ecmd, vecs[k].eaddr, vecs[k].emiss);
    end

    // Reset while waiting on tag 4, then stale tag-4 data must be dropped
    @(negedge clock);
    drive(32'h60, 1, 0, I, 64'h0, 0, I);
    #1 check("rw_miss", 0, 64'h0, N, 32'h0, 1);
    @(negedge clock);
    drive(32'h60, 1, 4, I, 64'h0, 0, I);
    #1 check("rw_req", 0, 64'h0, L, 32'h60, 1);
    @(negedge clock);
    reset = 1'b1;
    drive(32'h60, 0, 0, I, 64'h0, 0, I);
    #1 check("rw_wait", 0, 64'h0, N, 32'h0, 0);
    @(negedge clock);
    reset = 1'b0;
    drive(32'h60, 0, 0, I, 64'hFFFF_EEEE_DDDD_CCCC, 4, I);
    #1 check("rw_after_reset", 0, 64'h0, N, 32'h0, 0);
    @(negedge clock);
    drive(32'h60, 1, 0, I, 64'h0, 0, I);
    #1 check("rw_stale_dropped", 0, 64'h0, N, 32'h0, 1);
    @(negedge clock);
    drive(32'h48, 1, 0, I, 64'h0, 0, I);
    #1 check("rw_valid_cleared", 0, 64'h0, L, 32'h60, 1);
    @(negedge clock);
    drive(32'h48, 0, 0, I, 64'h0, 0, I);
    #1 check("rw_retarget", 0, 64'h0, L, 32'h48, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_fill_unit.md
# icache_fill_unit

Direct-mapped, blocking instruction cache with a single-outstanding-miss fill engine. It sits directly upstream of the memory controller: it drives that controller's icache request port and consumes its tagged response and data broadcast. Hits are returned to fetch combinationally. Misses issue one BUS_LOAD, capture the memory tag on grant, and write the line when the matching ICACHE-tagged data returns.

## Interface
- NUM_LINES, 32: number of 8-byte lines; power of 2, at least 2. IDX = log2(NUM_LINES).
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- proc2icache_addr  in  XLEN  fetch byte address
- proc2icache_valid  in  1  fetch request valid this cycle
- icache2proc_data  out  64  line holding the fetch address
- icache2proc_valid  out  1  hit; data valid this cycle
- icache_command  out  2  BUS_NONE or BUS_LOAD, to memory controller
- icache_addr  out  XLEN  8-byte-aligned line address being requested
- icache_is_miss  out  1  proc2icache_valid and not hit
- control2cache_response  in  4  memory tag granted this cycle; 0 means no grant
- control2cache_response_which  in  DEST_CACHE  owner of the grant
- control2cache_data  in  64  returned line
- control2cache_tag  in  4  tag of returned data; 0 means none
- control2cache_tag_which  in  DEST_CACHE  owner of the returned data

## Operation
- Address split:
  - offset = addr[2:0]
  - index = addr[IDX+2:3]
  - tag = addr[XLEN-1:IDX+3]
- Storage: NUM_LINES entries, each holding {valid, tag, 64-bit data}.
- hit = proc2icache_valid & valid[index] & (stored tag == tag).
  - icache2proc_data = data[index] when hit, else 0.
- FSM states:
  - IDLE: if proc2icache_valid & !hit, latch the line address and go to REQ.
  - REQ: drive icache_command = BUS_LOAD and icache_addr = latched line address.
    - If control2cache_response != 0 and control2cache_response_which == ICACHE, latch the response as mem_tag and go to WAIT.
    - If there is no grant and the proc address now names a different line that misses, update the latched address (no request is outstanding yet). If it now hits, return to IDLE.
  - WAIT: icache_command = BUS_NONE.
    - When control2cache_tag != 0, control2cache_tag_which == ICACHE and control2cache_tag == mem_tag: write data, tag and valid for the latched line, then go to IDLE.
    - A fetch address change in this state does not abandon the fill.
- Grants with which != ICACHE are ignored. Data with a non-matching tag or owner is ignored.
- icache_addr = {latched addr[XLEN-1:3], 3'b0} in REQ; 0 otherwise.
- Only one miss is in flight at a time; no new request issues outside REQ.

## Timing
- Reset (synchronous) produces:
  - state IDLE, all valid bits 0, mem_tag 0, latched address 0.
  - Outputs: icache2proc_valid 0, icache2proc_data 0, icache_command BUS_NONE, icache_addr 0.
  - icache_is_miss follows proc2icache_valid, since every line is invalid.
- Hit latency is 0 cycles (combinational from address).
- Miss timeline:
  - Cycle N: miss detected in IDLE.
  - Cycle N+1: REQ, command asserted, held until the grant cycle inclusive.
  - Grant cycle G: the edge after G moves to WAIT.
  - Data cycle D: the line is written at the edge ending D.
  - D+1: IDLE, hit visible for the same address.
- Minimum miss-to-hit is therefore G = N+1, D = G+1, hit at N+3.
- Data matching in the grant cycle itself is not possible; data is only checked in WAIT.
- Fill write and hit read of the same line in cycle D: the read returns the old contents (invalid); the new data is visible at D+1.
- Reset mid-REQ or mid-WAIT: return to IDLE and drop mem_tag. A later data return carrying the old tag is ignored and writes nothing.

## Test plan
- Cold miss:
  - Stimulus: addr 0x0000_1000 valid; grant tag 3 (ICACHE) one cycle after REQ; data 0xDEADBEEF_CAFEF00D with tag 3 (ICACHE) two cycles later.
  - Required response: BUS_LOAD with addr 0x1000 for exactly one cycle, then a hit returning 0xDEADBEEF_CAFEF00D; same-line addr 0x1004 also hits.
- Wrong-owner traffic:
  - Stimulus: in REQ, grant tag 5 with which=DCACHE.
  - Required response: stays in REQ with command held. Then, after a valid ICACHE grant of tag 5, DCACHE data with tag 5 is not written; only ICACHE data with tag 5 fills.
- Tag mismatch:
  - Stimulus: in WAIT with mem_tag 2, ICACHE data arrives with tag 7.
  - Required response: no write and no state change; data with tag 2 then completes the fill.
- Retarget before grant:
  - Stimulus: miss on 0x2000; in REQ with no grant, addr changes to 0x3000.
  - Required response: icache_addr becomes 0x3000, and the fill lands in the index for 0x3000.
- Conflict eviction:
  - Stimulus: fill 0x0000, then fill 0x0100 (same index when NUM_LINES=32).
  - Required response: 0x0100 hits and 0x0000 misses.
- Reset in WAIT:
  - Stimulus: assert reset while waiting on tag 4, then deliver ICACHE data with tag 4.
  - Required response: no valid line, all outputs at reset values, and a fetch of the same address misses.
